// File: rtl/cmd_fetch_unit_pkg.sv
// Shared types and constants for the command fetch unit.
//   CMD_WIDTH     : width of one instruction-memory command word
//   fetch_state_e : fetch sequencer states
//   sat_inc32     : saturating 32-bit increment used by the stall statistics counter
package cmd_fetch_unit_pkg;

    localparam int unsigned CMD_WIDTH  = 32;
    localparam int unsigned STAT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc32(input logic [STAT_WIDTH-1:0] v);
        return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/cmd_fetch_fifo.sv
// Synchronous show-ahead FIFO used as the command prefetch buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or when full and popping)
//   pop        : drop head entry (ignored when empty)
//   pop_data   : head entry, zero while empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0..DEPTH)
module cmd_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("cmd_fetch_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Gate the head so an empty FIFO never shows stale storage.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Full+pop may push: the slot being vacated is the one written.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // A push into a full FIFO without a simultaneous pop loses data.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
        else $error("cmd_fetch_fifo: push while full");

endmodule

// File: rtl/cmd_fetch_unit.sv
// Command fetch unit: on start, reads cmd_count words from instruction memory starting
// at base_addr, buffers them in a prefetch FIFO and presents them on a valid/ready port.
//   start/base_addr/cmd_count : run launch (sampled only when idle)
//   busy/done                 : run in progress / one-cycle completion pulse
//   mem_req_* / mem_rsp_*     : in-order read port, responses cannot be back-pressured
//   cmd/cmd_valid/cmd_ready   : command output handshake (FIFO head)
//   stall_cycles              : only with CMD_FETCH_STATS_EN defined; cycles with
//                               cmd_valid && !cmd_ready in the current/last run
module cmd_fetch_unit
    import cmd_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [CMD_WIDTH-1:0]  mem_rsp_data,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic                  cmd_valid,
    input  logic                  cmd_ready
`ifdef CMD_FETCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] stall_cycles
`endif
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  popped_q, popped_d;
    logic [OCC_W-1:0]      outst_q, outst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  req_valid_q, req_valid_d;

    logic                  req_fire;
    logic                  pop;
    logic                  push_acc;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OCC_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      fifo_cnt_d;
    logic [SUM_W-1:0]      occ_d;

    assign req_fire      = req_valid_q && mem_req_ready;
    assign pop           = cmd_valid && cmd_ready;
    assign push_acc      = mem_rsp_valid && (!fifo_full || pop);
    assign cmd_valid     = !fifo_empty;
    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = addr_q;

    // Prefetch buffer; responses are written unconditionally (credit rule keeps room).
    cmd_fetch_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mem_rsp_valid),
        .push_data (mem_rsp_data),
        .pop       (pop),
        .pop_data  (cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        outst_d    = outst_q;
        fifo_cnt_d = fifo_count;

        if (req_fire) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + CNT_WIDTH'(1);
        end
        if (pop) begin
            popped_d = popped_q + CNT_WIDTH'(1);
        end

        case ({req_fire, mem_rsp_valid})
            2'b10:   outst_d = outst_q + OCC_W'(1);
            2'b01:   outst_d = outst_q - OCC_W'(1);
            default: outst_d = outst_q;
        endcase

        case ({push_acc, pop})
            2'b10:   fifo_cnt_d = fifo_count + OCC_W'(1);
            2'b01:   fifo_cnt_d = fifo_count - OCC_W'(1);
            default: fifo_cnt_d = fifo_count;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    cnt_d    = cmd_count;
                    issued_d = '0;
                    popped_d = '0;
                    // An empty run passes through DRAIN so busy is seen for one cycle.
                    state_d  = (cmd_count == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (req_fire && (issued_d == cnt_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Using the post-pop count ends the run the cycle after the last pop.
                if (popped_d == cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Credit rule on next-cycle occupancy: every outstanding request owns a FIFO slot.
        occ_d       = SUM_W'(outst_d) + SUM_W'(fifo_cnt_d);
        req_valid_d = (state_d == ST_FETCH) && (issued_d != cnt_d) &&
                      (occ_d < SUM_W'(FIFO_DEPTH));
        busy_d      = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        done_d      = (state_d == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            outst_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            issued_q    <= issued_d;
            popped_q    <= popped_d;
            outst_q     <= outst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_valid_q <= req_valid_d;
        end
    end

`ifdef CMD_FETCH_STATS_EN
    logic [STAT_WIDTH-1:0] stall_q, stall_d;

    // Consumer back-pressure counter; cleared on an accepted start, holds between runs.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = '0;
        end else if (cmd_valid && !cmd_ready) begin
            stall_d = sat_inc32(stall_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cmd_fetch_unit.sv
// Directed bench for cmd_fetch_unit: in-order memory model with configurable latency
// and optional random request back-pressure; per-run event trace checked against
// hand-derived cycle numbers and data.
module tb_cmd_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] cmd_count = '0;
    logic        busy;
    logic        done;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [15:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
`ifdef CMD_FETCH_STATS_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    cmd_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .cmd_count     (cmd_count),
        .busy          (busy),
        .done          (done),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .cmd           (cmd),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready)
`ifdef CMD_FETCH_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [15:0] addr;
    } rsp_t;

    int   mem_lat  = 1;
    bit   rand_rdy = 1'b0;
    rsp_t mq[$];
    int   mcyc = 0;

    always begin
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
        end else if (mem_req_valid && mem_req_ready) begin
            mq.push_back('{mcyc + mem_lat, mem_req_addr});
        end
        @(posedge clk);
        mcyc++;
        #1;
        if (rst_n && mq.size() > 0 && mq[0].due <= mcyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {16'hC0DE, mq[0].addr};
            void'(mq.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        mem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- run trace ----------------
    logic [15:0] req_q[$];
    logic [31:0] got_q[$];
    int          first_req_k;
    int          last_pop_k;
    int          done_k;
    int          busy_n;
    int          stab_err;
    int          reqs_at_release;
    bit          done_busy;

    // Launch a run and trace it until done (or until reset is forced at abort_k).
    task automatic run(input logic [15:0] b, input logic [15:0] n, input int lat,
                       input bit rr, input int hold, input int abort_k);
        int          k;
        int          hold_left;
        bit          prev_stall;
        logic [15:0] prev_addr;
        req_q.delete();
        got_q.delete();
        first_req_k = -1; last_pop_k = -1; done_k = -1;
        busy_n = 0; stab_err = 0; reqs_at_release = -1; done_busy = 1'b0;
        hold_left = hold; prev_stall = 1'b0; prev_addr = '0;
        mem_lat = lat;
        rand_rdy = rr;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; cmd_count = n; cmd_ready = (hold == 0);
        k = 0;
        forever begin
            @(negedge clk);
            if (mem_req_valid && mem_req_ready) begin
                if (req_q.size() == 0) first_req_k = k;
                req_q.push_back(mem_req_addr);
            end
            if (prev_stall && !(mem_req_valid && mem_req_addr == prev_addr)) stab_err++;
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            if (cmd_valid && cmd_ready) begin
                got_q.push_back(cmd);
                last_pop_k = k;
            end
            if (cmd_valid && !cmd_ready && hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) reqs_at_release = req_q.size();
            end
            if (busy) busy_n++;
            if (done) begin
                done_k = k;
                done_busy = busy;
                break;
            end
            if (k >= 3000) begin
                check_eq("timeout", 32'(k), 32'd0);
                break;
            end
            @(posedge clk); #1;
            k++;
            // Junk on the launch inputs and a second start while busy must be ignored.
            start     = (k == 2);
            base_addr = 16'h5555;
            cmd_count = 16'd99;
            cmd_ready = (hold_left == 0);
            if (abort_k > 0 && k == abort_k) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
                check_eq("rst_req_addr", 32'(mem_req_addr), 32'd0);
                check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
                check_eq("rst_cmd", cmd, 32'd0);
`ifdef CMD_FETCH_STATS_EN
                check_eq("rst_stall", stall_cycles, 32'd0);
`endif
                @(posedge clk); #1;
                rst_n = 1'b1;
                cmd_ready = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Compare traced request addresses and delivered commands with the expected sequence.
    task automatic check_seq(input string tag, input logic [15:0] b, input int n);
        logic [15:0] a;
        check_eq({tag, "_nreq"}, 32'(req_q.size()), 32'(n));
        check_eq({tag, "_ncmd"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
            if (i < req_q.size()) check_eq($sformatf("%s_addr%0d", tag, i), 32'(req_q[i]), 32'(a));
            if (i < got_q.size()) check_eq($sformatf("%s_cmd%0d", tag, i), got_q[i], {16'hC0DE, a});
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("reset_cmd", cmd, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);

        // 1: three commands, 1-cycle memory, consumer always ready
        run(16'h0010, 16'd3, 1, 1'b0, 0, 0);
        check_seq("t1", 16'h0010, 3);
        check_eq("t1_first_req", 32'(first_req_k), 32'd1);
        check_eq("t1_last_pop", 32'(last_pop_k), 32'd5);
        check_eq("t1_done_cycle", 32'(done_k), 32'd6);
        check_eq("t1_busy_at_done", 32'(done_busy), 32'd0);
        check_eq("t1_busy_cycles", 32'(busy_n), 32'd5);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(done), 32'd0);
`ifdef CMD_FETCH_STATS_EN
        check_eq("t1_stall", stall_cycles, 32'd0);
`endif

        // 2: empty run
        run(16'h0100, 16'd0, 1, 1'b0, 0, 0);
        check_eq("t2_nreq", 32'(req_q.size()), 32'd0);
        check_eq("t2_done_cycle", 32'(done_k), 32'd2);
        check_eq("t2_busy_cycles", 32'(busy_n), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("t2_idle_after", 32'(busy), 32'd0);

        // 3: consumer stalls 20 cycles; issue stops at FIFO depth
        run(16'h0300, 16'd10, 1, 1'b0, 20, 0);
        check_eq("t3_reqs_at_release", 32'(reqs_at_release), 32'd4);
        check_seq("t3", 16'h0300, 10);
`ifdef CMD_FETCH_STATS_EN
        check_eq("t3_stall", stall_cycles, 32'd20);
`endif

        // 4: address wrap
        run(16'hFFFE, 16'd4, 1, 1'b0, 0, 0);
        check_seq("t4", 16'hFFFE, 4);

        // 5: random request back-pressure, 3-cycle memory
        run(16'h0200, 16'd12, 3, 1'b1, 0, 0);
        check_seq("t5", 16'h0200, 12);
        check_eq("t5_addr_stable", 32'(stab_err), 32'd0);
        rand_rdy = 1'b0;

        // 6: reset in DRAIN, then a clean run
        run(16'h0500, 16'd4, 1, 1'b0, 1000, 10);
        @(posedge clk); #1;
        run(16'h0040, 16'd2, 1, 1'b0, 0, 0);
        check_seq("t6", 16'h0040, 2);
        check_eq("t6_done_cycle", 32'(done_k), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
